i2c_target_responder: RTL

// - I2C target (responder) with one 7-bit address; the bus end opposite the I2C controllers.
// - Write transfer: bytes from the controller go into a receive buffer.
// - Read transfer: bytes from a parallel transmit buffer are returned to the controller.
// - Oversamples SCL/SDA on the system clock. Drives SDA low only (open-drain). Never stretches SCL.

---
 rtl/i2c_target_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_responder.sv
// i2c_target_responder: single-address I2C target with RX/TX byte buffers, oversampled on clk.
// SDA is only ever pulled low; SCL is never stretched.
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR  = 7'b1000111,
    parameter int         BYTES_RX_LOG = 2,
    parameter int         BYTES_TX_LOG = 2,
    localparam int        RX_BITS      = (2**BYTES_RX_LOG - 1) * 8,
    localparam int        TX_BITS      = (2**BYTES_TX_LOG - 1) * 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    sda_oe,
    input  logic [TX_BITS-1:0]      tx_data,
    output logic [RX_BITS-1:0]      rx_data,
    output logic [BYTES_RX_LOG-1:0] rx_count,
    output logic                    rx_valid,
    output logic [BYTES_TX_LOG-1:0] tx_count,
    output logic                    busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE} state_t;
    localparam logic [BYTES_RX_LOG-1:0] RX_CAP = '1;
    localparam logic [BYTES_TX_LOG-1:0] TX_CAP = '1;

    logic r_scl_s1, r_scl_s2, r_scl_d, r_sda_s1, r_sda_s2, r_sda_d;
    state_t r_state, w_state_n;
    logic [2:0] r_cnt, w_cnt_n;
    logic [7:0] r_sh, w_sh_n;
    logic r_rw, w_rw_n, r_ack, w_ack_n, r_oe, w_oe_n, r_wr, w_wr_n;
    logic [RX_BITS-1:0] r_rx_data, w_rx_data_n;
    logic [BYTES_RX_LOG-1:0] r_rx_count, w_rx_count_n;
    logic r_rx_valid, w_rx_valid_n, r_busy, w_busy_n;
    logic [BYTES_TX_LOG-1:0] r_tx_count, w_tx_count_n;
    logic [TX_BITS-1:0] r_txs, w_txs_n;
    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_match;
    logic [7:0] w_cur;

    // Sync flops idle high so reset never looks like a bus edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_i, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_i, r_sda_s1, r_sda_s2};
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & ~r_sda_d & r_sda_s2;
    assign w_match    = r_sh[6:0] == TARGET_ADDR;
    assign w_cur      = r_txs[TX_BITS-1 -: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sh       <= '0;
            r_rw       <= 1'b0;
            r_ack      <= 1'b0;
            r_oe       <= 1'b0;
            r_wr       <= 1'b0;
            r_rx_data  <= '0;
            r_rx_count <= '0;
            r_rx_valid <= 1'b0;
            r_tx_count <= '0;
            r_busy     <= 1'b0;
            r_txs      <= '0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_sh       <= w_sh_n;
            r_rw       <= w_rw_n;
            r_ack      <= w_ack_n;
            r_oe       <= w_oe_n;
            r_wr       <= w_wr_n;
            r_rx_data  <= w_rx_data_n;
            r_rx_count <= w_rx_count_n;
            r_rx_valid <= w_rx_valid_n;
            r_tx_count <= w_tx_count_n;
            r_busy     <= w_busy_n;
            r_txs      <= w_txs_n;
        end
    end

    // r_ack marks that the ACK slot has been driven; the next SCL fall ends it.
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_sh_n       = r_sh;
        w_rw_n       = r_rw;
        w_ack_n      = r_ack;
        w_oe_n       = r_oe;
        w_wr_n       = r_wr;
        w_rx_data_n  = r_rx_data;
        w_rx_count_n = r_rx_count;
        w_rx_valid_n = 1'b0;
        w_tx_count_n = r_tx_count;
        w_busy_n     = r_busy;
        w_txs_n      = r_txs;
        if (w_start || w_stop) begin
            w_state_n    = w_start ? ADDR : IDLE;
            w_cnt_n      = '0;
            w_ack_n      = 1'b0;
            w_oe_n       = 1'b0;
            w_busy_n     = 1'b0;
            w_wr_n       = 1'b0;
            w_rx_valid_n = r_wr && (r_rx_count != '0);
        end else begin
            case (r_state)
                ADDR: if (w_scl_rise) begin
                    w_sh_n  = {r_sh[6:0], r_sda_s2};
                    w_cnt_n = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_state_n = w_match ? ADDR_ACK : IGNORE;
                        if (w_match) begin
                            w_busy_n     = 1'b1;
                            w_rw_n       = r_sda_s2;
                            w_wr_n       = ~r_sda_s2;
                            w_ack_n      = 1'b0;
                            w_tx_count_n = r_sda_s2 ? '0 : r_tx_count;
                            w_rx_count_n = r_sda_s2 ? r_rx_count : '0;
                            w_rx_data_n  = r_sda_s2 ? r_rx_data : '0;
                        end
                    end
                end
                ADDR_ACK: if (w_scl_fall) begin
                    w_ack_n = ~r_ack;
                    if (!r_ack) begin
                        w_oe_n  = 1'b1;
                        w_txs_n = r_rw ? tx_data : r_txs;
                    end else begin
                        w_oe_n    = r_rw & ~r_txs[TX_BITS-1];
                        w_state_n = r_rw ? TX_BYTE : RX_BYTE;
                    end
                end
                RX_BYTE: if (w_scl_rise) begin
                    w_sh_n    = {r_sh[6:0], r_sda_s2};
                    w_cnt_n   = r_cnt + 3'd1;
                    w_state_n = (r_cnt == 3'd7) ? RX_ACK : RX_BYTE;
                end
                RX_ACK: if (w_scl_fall) begin
                    if (r_ack) begin
                        w_oe_n    = 1'b0;
                        w_ack_n   = 1'b0;
                        w_state_n = RX_BYTE;
                    end else if (r_rx_count != RX_CAP) begin
                        w_rx_data_n  = {r_rx_data[RX_BITS-9:0], r_sh};
                        w_rx_count_n = r_rx_count + 1'b1;
                        w_oe_n       = 1'b1;
                        w_ack_n      = 1'b1;
                    end else begin
                        w_state_n = IGNORE;
                    end
                end
                TX_BYTE: if (w_scl_rise) begin
                    w_cnt_n   = r_cnt + 3'd1;
                    w_state_n = (r_cnt == 3'd7) ? TX_ACK : TX_BYTE;
                end else if (w_scl_fall) begin
                    w_oe_n = ~w_cur[3'd7 - r_cnt];
                end
                TX_ACK: if (w_scl_fall) begin
                    w_oe_n = 1'b0;
                end else if (w_scl_rise) begin
                    w_state_n    = r_sda_s2 ? IGNORE : TX_BYTE;
                    w_tx_count_n = (!r_sda_s2 && r_tx_count != TX_CAP) ? r_tx_count + 1'b1 : r_tx_count;
                    w_txs_n      = r_sda_s2 ? r_txs : {r_txs[TX_BITS-9:0], 8'hFF};
                end
                default: ;
            endcase
        end
    end

    assign sda_oe   = r_oe;
    assign rx_data  = r_rx_data;
    assign rx_count = r_rx_count;
    assign rx_valid = r_rx_valid;
    assign tx_count = r_tx_count;
    assign busy     = r_busy;
endmodule
